// File: rtl/allocator_lsu.sv
// Free-list allocator load/store unit: serialises LOCK/UNLOCK/LOAD/INSERT/DELETE
// requests into single-beat memory transactions and returns the updated block header.
package allocator_lsu_pkg;
    localparam logic [63:0] EMPTY_KEY              = 64'h0;
    localparam logic [63:0] BLOCK_NEXT_ADDR_OFFSET = 64'h8;

    localparam logic [2:0] LSU_LOCK            = 3'd0;
    localparam logic [2:0] LSU_UNLOCK          = 3'd1;
    localparam logic [2:0] LSU_LOAD            = 3'd2;
    localparam logic [2:0] LSU_SET_INSERT_ADDR = 3'd3;
    localparam logic [2:0] LSU_INSERT          = 3'd4;
    localparam logic [2:0] LSU_DELETE          = 3'd5;

    typedef struct packed {
        logic [63:0] addr;
        logic [63:0] size;
        logic [63:0] next_addr;
    } header_data_t;

    typedef struct packed {
        logic         val;
        logic [2:0]   lsu_op;
        header_data_t header_data;
    } header_data_req_t;

    typedef struct packed {
        logic         val;
        header_data_t header_data;
    } header_data_rsp_t;

    typedef enum logic [3:0] {
        IDLE, LOCK_RD, LOCK_WAIT, LOCK_WR, RD_SIZE, RD_NEXT,
        WR_SIZE, WR_NEXT, WR_LINK, RESP
    } alloc_state_e;
endpackage

// Handshakes: req_i is taken on req_i.val && req_ready_o; a memory request is
// held unchanged while mem_req_o && !mem_gnt_i and retires on the grant cycle;
// a granted read then completes on the first mem_rvalid_i seen in its state.
module allocator_lsu
    import allocator_lsu_pkg::*;
#(
    parameter logic [63:0] HEAD_ADDR = 64'h0000_0000_0000_1000,
    parameter logic [63:0] LOCK_ADDR = 64'h0000_0000_0000_1008
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  header_data_req_t req_i,
    output logic             req_ready_o,
    output header_data_rsp_t rsp_o,
    output logic             mem_req_o,
    output logic             mem_we_o,
    output logic [63:0]      mem_addr_o,
    output logic [63:0]      mem_wdata_o,
    input  logic             mem_gnt_i,
    input  logic             mem_rvalid_i,
    input  logic [63:0]      mem_rdata_i
);
    alloc_state_e state;
    alloc_state_e state_next;

    logic [2:0]   op_q;
    logic [63:0]  addr_q;
    logic [63:0]  size_q;
    logic [63:0]  next_q;
    logic [63:0]  insert_addr_q;
    logic         rd_pending;
    header_data_t rsp_hd_q;
    logic [63:0]  link_addr;
    logic         in_read;
    logic         rd_done;

    assign link_addr = (insert_addr_q == EMPTY_KEY) ? HEAD_ADDR
                                                    : insert_addr_q + BLOCK_NEXT_ADDR_OFFSET;
    assign in_read   = (state == LOCK_RD) || (state == RD_SIZE) || (state == RD_NEXT);
    assign rd_done   = in_read && rd_pending && mem_rvalid_i;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (req_i.val) begin
                    case (req_i.lsu_op)
                        LSU_LOCK:   state_next = LOCK_RD;
                        LSU_UNLOCK: state_next = LOCK_WR;
                        LSU_LOAD:   state_next = RD_SIZE;
                        LSU_INSERT: state_next = WR_SIZE;
                        LSU_DELETE: state_next = WR_LINK;
                        default:    state_next = RESP;
                    endcase
                end
            end
            // A held lock costs one back-off cycle before the read is re-issued.
            LOCK_RD:   if (rd_done) state_next = (mem_rdata_i == 64'h0) ? LOCK_WR : LOCK_WAIT;
            LOCK_WAIT: state_next = LOCK_RD;
            LOCK_WR:   if (mem_gnt_i) state_next = RESP;
            RD_SIZE:   if (rd_done) state_next = RD_NEXT;
            RD_NEXT:   if (rd_done) state_next = RESP;
            WR_SIZE:   if (mem_gnt_i) state_next = WR_NEXT;
            WR_NEXT:   if (mem_gnt_i) state_next = WR_LINK;
            WR_LINK:   if (mem_gnt_i) state_next = RESP;
            RESP:      state_next = IDLE;
            default:   state_next = IDLE;
        endcase
    end

    always_comb begin
        mem_req_o   = 1'b0;
        mem_we_o    = 1'b0;
        mem_addr_o  = 64'h0;
        mem_wdata_o = 64'h0;
        case (state)
            LOCK_RD: begin
                mem_req_o  = !rd_pending;
                mem_addr_o = rd_pending ? 64'h0 : LOCK_ADDR;
            end
            LOCK_WR: begin
                mem_req_o   = 1'b1;
                mem_we_o    = 1'b1;
                mem_addr_o  = LOCK_ADDR;
                mem_wdata_o = (op_q == LSU_LOCK) ? 64'h1 : 64'h0;
            end
            RD_SIZE: begin
                mem_req_o  = !rd_pending;
                mem_addr_o = rd_pending ? 64'h0 : addr_q;
            end
            RD_NEXT: begin
                mem_req_o  = !rd_pending;
                mem_addr_o = rd_pending ? 64'h0 : addr_q + BLOCK_NEXT_ADDR_OFFSET;
            end
            WR_SIZE: begin
                mem_req_o   = 1'b1;
                mem_we_o    = 1'b1;
                mem_addr_o  = addr_q;
                mem_wdata_o = size_q;
            end
            WR_NEXT: begin
                mem_req_o   = 1'b1;
                mem_we_o    = 1'b1;
                mem_addr_o  = addr_q + BLOCK_NEXT_ADDR_OFFSET;
                mem_wdata_o = next_q;
            end
            WR_LINK: begin
                mem_req_o   = 1'b1;
                mem_we_o    = 1'b1;
                mem_addr_o  = link_addr;
                mem_wdata_o = (op_q == LSU_INSERT) ? addr_q : next_q;
            end
            default: ;
        endcase
        req_ready_o       = (state == IDLE);
        rsp_o.val         = (state == RESP);
        rsp_o.header_data = (state == RESP) ? '{addr_q, size_q, next_q} : rsp_hd_q;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            op_q          <= 3'd0;
            addr_q        <= 64'h0;
            size_q        <= 64'h0;
            next_q        <= 64'h0;
            insert_addr_q <= EMPTY_KEY;
            rd_pending    <= 1'b0;
            rsp_hd_q      <= '0;
        end else begin
            if (state == IDLE && req_i.val) begin
                op_q   <= req_i.lsu_op;
                addr_q <= req_i.header_data.addr;
                size_q <= req_i.header_data.size;
                next_q <= req_i.header_data.next_addr;
                if (req_i.lsu_op == LSU_SET_INSERT_ADDR) begin
                    insert_addr_q <= req_i.header_data.addr;
                end
            end
            if (in_read && !rd_pending && mem_gnt_i) begin
                rd_pending <= 1'b1;
            end else if (rd_done) begin
                rd_pending <= 1'b0;
                if (state == RD_SIZE) size_q <= mem_rdata_i;
                if (state == RD_NEXT) next_q <= mem_rdata_i;
            end
            if (state == RESP) begin
                rsp_hd_q <= '{addr_q, size_q, next_q};
            end
        end
    end
endmodule

// File: doc/allocator_lsu.md
ALLOCATOR_LSU -- requirements
Module: allocator_lsu

Interface
REQ-001 SHALL have parameter HEAD_ADDR, default 64'h0000_0000_0000_1000, meaning address of the free-list head pointer word.
REQ-002 SHALL have parameter LOCK_ADDR, default 64'h0000_0000_0000_1008, meaning address of the allocator lock word.
REQ-003 SHALL have ports, in this order:
- clk_i, input, 1, single clock.
- rst_i, input, 1, synchronous active-high reset.
- req_i, input, header_data_req_t, request; valid = req_i.val.
- req_ready_o, output, 1, high only in IDLE.
- rsp_o, output, header_data_rsp_t, response; rsp_o.val is a one-cycle pulse.
- mem_req_o, output, 1, memory request valid.
- mem_we_o, output, 1, 1 = write, 0 = read.
- mem_addr_o, output, 64, byte address.
- mem_wdata_o, output, 64, write data.
- mem_gnt_i, input, 1, request accepted.
- mem_rvalid_i, input, 1, read data valid.
- mem_rdata_i, input, 64, read data.

Function
REQ-004 SHALL accept a request when req_i.val && req_ready_o, latching header_data and lsu_op.
REQ-005 SHALL hold mem_req_o, mem_we_o, mem_addr_o and mem_wdata_o stable until mem_gnt_i; a write completes on its grant cycle.
REQ-006 SHALL keep at most one read outstanding; a read completes on mem_rvalid_i; mem_rvalid_i outside a wait state SHALL be ignored.
REQ-007 SHALL use FSM states IDLE, LOCK_RD, LOCK_WAIT, LOCK_WR, RD_SIZE, RD_NEXT, WR_SIZE, WR_NEXT, WR_LINK, RESP; each read state includes its rvalid wait.
REQ-008 LOCK SHALL:
- read LOCK_ADDR;
- if rdata != 0, re-issue the read (spin);
- if rdata == 0, write 64'h1 to LOCK_ADDR, then go to RESP.
REQ-009 UNLOCK SHALL write 64'h0 to LOCK_ADDR, then go to RESP.
REQ-010 LOAD SHALL read addr into size, then read addr+BLOCK_NEXT_ADDR_OFFSET into next_addr, then go to RESP.
REQ-011 SET_INSERT_ADDR SHALL load header_data.addr into internal register insert_addr with no memory access, then go to RESP.
REQ-012 INSERT SHALL issue three writes, in order:
- size to addr;
- next_addr to addr+8;
- addr to link_addr.
REQ-013 DELETE SHALL write next_addr to link_addr (single write).
REQ-014 link_addr SHALL be HEAD_ADDR when insert_addr == EMPTY_KEY, else insert_addr+BLOCK_NEXT_ADDR_OFFSET.
REQ-015 Address arithmetic SHALL be 64-bit modulo 2^64, with no overflow detection.
REQ-016 RESP SHALL:
- assert rsp_o.val for exactly one cycle;
- drive rsp_o.header_data = {latched addr, size, next_addr}, where size and next_addr are read values for LOAD and latched values otherwise;
- return to IDLE on the next cycle.
REQ-017 Minimum latency, counted from the accept cycle: SET_INSERT_ADDR rsp at +1; UNLOCK/DELETE at +2 with zero-wait grant; LOAD at +1 plus two read round trips.
REQ-018 An unknown lsu_op SHALL go directly to RESP echoing the latched header, with no memory access.
REQ-019 req_i SHALL be ignored while not in IDLE.
REQ-020 rsp_o.header_data SHALL hold its last value when rsp_o.val is low.

Reset
REQ-021 On rst_i high at a clock edge, the block SHALL:
- enter IDLE;
- drive mem_req_o=0, mem_we_o=0, mem_addr_o=0, mem_wdata_o=0, rsp_o='0, req_ready_o=1 from the next cycle;
- set insert_addr=EMPTY_KEY.
REQ-022 Reset mid-operation SHALL abandon the transaction without a response; a later mem_rvalid_i SHALL be ignored.

Verification
REQ-023 LOAD with addr=0x2000, memory [0x2000]=0x40 and [0x2008]=0x3000 -> two reads at 0x2000 then 0x2008; rsp {0x2000, 0x40, 0x3000} pulsed once.
REQ-024 LOCK with [LOCK_ADDR] reading 1, 1, then 0 -> three reads, then one write of 1 to 0x1008, then rsp; UNLOCK -> one write of 0 to 0x1008.
REQ-025 INSERT {0x4000, 0x80, 0x5000} after reset (insert_addr empty) -> writes [0x4000]=0x80, [0x4008]=0x5000, [0x1000]=0x4000, in order.
REQ-026 SET_INSERT_ADDR addr=0x6000, then DELETE next_addr=0x7000 -> SET rsp at +1 with no memory traffic; DELETE writes [0x6008]=0x7000.
REQ-027 mem_gnt_i held low 5 cycles during WR_NEXT -> address and data stable all 5 cycles; rst_i asserted in RD_NEXT -> no rsp; req_ready_o=1 on the next cycle; late mem_rvalid_i ignored.
